// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer: keeps one 32-byte line, answers hits in the
// same cycle and refills the line from memory as a 4-beat 64-bit burst.
module ifetch_line_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_addr_i,
  input  logic        if_read_i,
  input  logic        if_inv_i,
  output logic [31:0] if_rdata_o,
  output logic        if_resp_o,
  output logic [31:0] pmem_address_o,
  output logic        pmem_read_o,
  input  logic [63:0] pmem_rdata_i,
  input  logic        pmem_resp_i
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]   state_r;
  logic [1:0]   beat_r;
  logic         valid_r;
  logic         kill_r;
  logic [26:0]  tag_r;
  logic [26:0]  fill_tag_r;
  logic [255:0] line_r;

  logic         hit_s;
  logic         miss_s;
  logic         fill_beat_s;
  logic         last_beat_s;
  logic [7:0]   word_lsb_s;
  logic [7:0]   beat_lsb_s;

  // Hit/miss decode for the current fetch request
  always_comb begin
    hit_s  = 1'b0;
    miss_s = 1'b0;
    if ((state_r == IDLE) && if_read_i) begin
      if (valid_r && (tag_r == if_addr_i[31:5])) begin
        hit_s = 1'b1;
      end else begin
        miss_s = 1'b1;
      end
    end else begin
      hit_s  = 1'b0;
      miss_s = 1'b0;
    end
  end

  // Beat acceptance while the burst is in flight
  always_comb begin
    fill_beat_s = 1'b0;
    last_beat_s = 1'b0;
    if ((state_r == FILL) && pmem_resp_i) begin
      fill_beat_s = 1'b1;
      last_beat_s = (beat_r == 2'd3);
    end else begin
      fill_beat_s = 1'b0;
      last_beat_s = 1'b0;
    end
  end

  assign word_lsb_s = {if_addr_i[4:2], 5'd0};
  assign beat_lsb_s = {beat_r, 6'd0};
  assign if_rdata_o = line_r[word_lsb_s +: 32];
  assign if_resp_o  = hit_s;

  // Memory request outputs derive only from registered state
  always_comb begin
    pmem_read_o    = 1'b0;
    pmem_address_o = 32'd0;
    case (state_r)
      FILL: begin
        pmem_read_o    = 1'b1;
        pmem_address_o = {fill_tag_r, 5'd0};
      end
      default: begin
        pmem_read_o    = 1'b0;
        pmem_address_o = 32'd0;
      end
    endcase
  end

  // Control state: FSM, beat counter, valid and invalidate-during-fill flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      beat_r  <= 2'd0;
      valid_r <= 1'b0;
      kill_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          kill_r <= 1'b0;
          if (if_inv_i) begin
            valid_r <= 1'b0;
          end
          if (miss_s) begin
            beat_r  <= 2'd0;
            state_r <= FILL;
          end
        end
        FILL: begin
          if (fill_beat_s) begin
            beat_r <= beat_r + 2'd1;
          end
          if (last_beat_s) begin
            // A flush seen anywhere in this fill leaves the fresh line unusable
            state_r <= IDLE;
            valid_r <= ~(kill_r | if_inv_i);
            kill_r  <= 1'b0;
          end else if (if_inv_i) begin
            kill_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          beat_r  <= 2'd0;
          valid_r <= 1'b0;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

  // Line storage and tags; contents may stay stale across reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (miss_s) begin
        fill_tag_r <= if_addr_i[31:5];
      end
      if (fill_beat_s) begin
        line_r[beat_lsb_s +: 64] <= pmem_rdata_i;
      end
      if (last_beat_s) begin
        tag_r <= fill_tag_r;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Directed bench for ifetch_line_buffer with a memory model, a burst responder
// and a scoreboard of expected fetch words.
module tb_ifetch_line_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_addr_i;
  logic        if_read_i;
  logic        if_inv_i;
  logic [31:0] if_rdata_o;
  logic        if_resp_o;
  logic [31:0] pmem_address_o;
  logic        pmem_read_o;
  logic [63:0] pmem_rdata_i;
  logic        pmem_resp_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  ifetch_line_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .if_addr_i      (if_addr_i),
    .if_read_i      (if_read_i),
    .if_inv_i       (if_inv_i),
    .if_rdata_o     (if_rdata_o),
    .if_resp_o      (if_resp_o),
    .pmem_address_o (pmem_address_o),
    .pmem_read_o    (pmem_read_o),
    .pmem_rdata_i   (pmem_rdata_i),
    .pmem_resp_i    (pmem_resp_i)
  );

  always #5 clk = ~clk;

  // Word i of line 0x1000 is i*0x1111_1111; other lines are xor-scrambled by address.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {29'd0, a[4:2]};
    return (idx * 32'h1111_1111) ^ ({a[31:5], 5'd0} ^ 32'h0000_1000);
  endfunction

  function automatic logic [63:0] model_beat(input logic [31:0] line, input int k);
    logic [31:0] lo, hi;
    lo = model_word(line | 32'(k * 8));
    hi = model_word(line | 32'(k * 8 + 4));
    return {hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic rd, input logic inv,
                       input logic rsp, input logic [63:0] dat, input logic r);
    @(posedge clk); #1;
    if_addr_i = a; if_read_i = rd; if_inv_i = inv;
    pmem_resp_i = rsp; pmem_rdata_i = dat; rst = r;
  endtask

  // Hold a fetch until it is answered, acting as the memory for any bursts it causes.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int switch_at, input int gap_max, input int inv_at,
                       input int exp_bursts, input int exp_lat);
    int lat, beats, gap, bursts, fill_cyc;
    bit done, rd_prev, last_beat, after_last;
    logic [31:0] cur, prev, exp_line;
    cur = a; prev = a; lat = 0; beats = 0; gap = 0; bursts = 0; fill_cyc = 0;
    done = 1'b0; rd_prev = 1'b0; last_beat = 1'b0; after_last = 1'b0; exp_line = 32'd0;
    sb_q.push_back(model_word((switch_at > 0) ? b : a));
    while (!done && lat < 80) begin
      @(posedge clk); #1;
      rst = 1'b0;
      after_last = last_beat;
      if (pmem_read_o) begin
        if (!rd_prev) begin
          bursts++;
          exp_line = {prev[31:5], 5'd0};
          beats = 0;
        end
        fill_cyc++;
      end
      rd_prev = pmem_read_o;
      if (switch_at > 0 && fill_cyc == switch_at) cur = b;
      if_addr_i = cur;
      if_read_i = 1'b1;
      if_inv_i  = (pmem_read_o && fill_cyc == inv_at);
      if (pmem_read_o && gap == 0 && beats < 4) begin
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = model_beat(exp_line, beats);
        beats++;
        gap = int'($urandom_range(32'(gap_max), 32'd0));
        last_beat = (beats == 4);
      end else begin
        pmem_resp_i  = 1'b0;
        pmem_rdata_i = {$urandom, $urandom};
        if (gap > 0) gap--;
        last_beat = 1'b0;
      end
      prev = cur;
      @(negedge clk);
      if (pmem_read_o) chk({tag, "_pmem_addr"}, pmem_address_o, exp_line);
      if (after_last)  chk({tag, "_read_drop"}, {31'd0, pmem_read_o}, 32'd0);
      if (if_resp_o) begin
        pop_chk({tag, "_rdata"}, if_rdata_o);
        done = 1'b1;
      end else begin
        lat++;
      end
    end
    chk({tag, "_answered"}, {31'd0, done}, 32'd1);
    chk({tag, "_bursts"}, 32'(bursts), 32'(exp_bursts));
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    rst = 1'b1; if_addr_i = 32'd0; if_read_i = 1'b0; if_inv_i = 1'b0;
    pmem_resp_i = 1'b0; pmem_rdata_i = 64'd0;

    // Reset, with a read and invalidate asserted to show reset wins
    drive(32'h0000_1004, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
    drive(32'h0000_1004, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
    @(negedge clk);
    chk("rst_resp", {31'd0, if_resp_o}, 32'd0);
    chk("rst_pmem_read", {31'd0, pmem_read_o}, 32'd0);
    chk("rst_pmem_addr", pmem_address_o, 32'd0);

    // No request in IDLE: no response, no fill
    drive(32'h0000_1004, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    drive(32'h0000_1004, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    chk("noread_resp", {31'd0, if_resp_o}, 32'd0);
    chk("noread_pmem_read", {31'd0, pmem_read_o}, 32'd0);

    // Cold miss, then same-line hits back-to-back
    fetch("cold_miss", 32'h0000_1004, 32'd0, 0, 0, 0, 1, 5);
    fetch("hit_1000", 32'h0000_1000, 32'd0, 0, 0, 0, 0, 0);
    fetch("hit_101c", 32'h0000_101C, 32'd0, 0, 0, 0, 0, 0);

    // Stalled beats with random gaps
    fetch("stall_fill", 32'h0000_4008, 32'd0, 0, 3, 0, 1, -1);
    fetch("stall_hit", 32'h0000_4014, 32'd0, 0, 0, 0, 0, 0);

    // Invalidate in IDLE alongside a hit still returns it; the next access misses
    drive(32'h0000_4008, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    sb_q.push_back(model_word(32'h0000_4008));
    @(negedge clk);
    chk("inv_hit_resp", {31'd0, if_resp_o}, 32'd1);
    pop_chk("inv_hit_rdata", if_rdata_o);
    drive(32'h0000_4008, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    chk("inv_idle_pmem_read", {31'd0, pmem_read_o}, 32'd0);
    fetch("after_inv", 32'h0000_4008, 32'd0, 0, 0, 0, 1, 5);

    // Invalidate on the 2nd fill cycle: fill completes, re-request refills
    fetch("inv_fill", 32'h0000_5004, 32'd0, 0, 0, 2, 2, 10);
    fetch("inv_fill_hit", 32'h0000_5018, 32'd0, 0, 0, 0, 0, 0);

    // Address change during fill: fill stays at 0x1000, then 0x2000 misses
    fetch("addr_switch", 32'h0000_1000, 32'h0000_2000, 2, 0, 0, 2, 10);
    fetch("switch_hit", 32'h0000_200C, 32'd0, 0, 0, 0, 0, 0);

    // Reset on the 2nd beat aborts the burst; late beats are ignored
    drive(32'h0000_3000, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    drive(32'h0000_3000, 1'b1, 1'b0, 1'b1, model_beat(32'h0000_3000, 0), 1'b0);
    drive(32'h0000_3000, 1'b1, 1'b0, 1'b1, model_beat(32'h0000_3000, 1), 1'b1);
    drive(32'h0000_3000, 1'b0, 1'b0, 1'b1, model_beat(32'h0000_3000, 2), 1'b0);
    @(negedge clk);
    chk("rst_fill_pmem_read", {31'd0, pmem_read_o}, 32'd0);
    chk("rst_fill_pmem_addr", pmem_address_o, 32'd0);
    chk("rst_fill_resp", {31'd0, if_resp_o}, 32'd0);
    drive(32'h0000_3000, 1'b0, 1'b0, 1'b1, model_beat(32'h0000_3000, 3), 1'b0);
    @(negedge clk);
    chk("late_beat_pmem_read", {31'd0, pmem_read_o}, 32'd0);
    fetch("after_rst_fill", 32'h0000_3000, 32'd0, 0, 0, 0, 1, 5);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
